// File: rtl/memory_arbiter.sv
// Two-client block arbiter: instruction-cache reads and data-cache reads/write-backs
// share one main-memory port. Ties are resolved round-robin against the last grant.
module memory_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   I_READ,
    input  logic [ADDR_WIDTH-1:0]  I_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_READDATA,
    output logic                   I_BUSYWAIT,
    input  logic                   D_READ,
    input  logic                   D_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] D_READDATA,
    output logic                   D_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic GrantI = 1'b0;
    localparam logic GrantD = 1'b1;

    state_e                 state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic                   mem_read_d, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_address_d;
    logic [BLOCK_WIDTH-1:0] mem_writedata_d;
    logic [BLOCK_WIDTH-1:0] i_readdata_d, d_readdata_d;
    logic                   i_req, d_req;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    // Next-state, grant decision and datapath updates; everything holds by default.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        mem_read_d      = MEM_READ;
        mem_write_d     = MEM_WRITE;
        mem_address_d   = MEM_ADDRESS;
        mem_writedata_d = MEM_WRITEDATA;
        i_readdata_d    = I_READDATA;
        d_readdata_d    = D_READDATA;
        unique case (state_q)
            StIdle: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        grant_d = (last_grant_q == GrantI) ? GrantD : GrantI;
                    end else begin
                        grant_d = d_req ? GrantD : GrantI;
                    end
                    last_grant_d = grant_d;
                    state_d      = StIssue;
                    if (grant_d == GrantD) begin
                        mem_address_d = D_ADDRESS;
                        // A simultaneous read+write request is a write-back.
                        if (D_WRITE) begin
                            mem_write_d     = 1'b1;
                            mem_writedata_d = D_WRITEDATA;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        mem_address_d = I_ADDRESS;
                        mem_read_d    = 1'b1;
                    end
                end
            end
            // Memory busywait is not yet meaningful in the first strobe cycle.
            StIssue: state_d = StWait;
            StWait: begin
                if (!MEM_BUSYWAIT) begin
                    if (MEM_READ) begin
                        if (grant_q == GrantD) begin
                            d_readdata_d = MEM_READDATA;
                        end else begin
                            i_readdata_d = MEM_READDATA;
                        end
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and registered memory/cache-side outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant_q       <= GrantI;
            last_grant_q  <= GrantI;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            MEM_READ      <= mem_read_d;
            MEM_WRITE     <= mem_write_d;
            MEM_ADDRESS   <= mem_address_d;
            MEM_WRITEDATA <= mem_writedata_d;
            I_READDATA    <= i_readdata_d;
            D_READDATA    <= d_readdata_d;
        end
    end

    assign I_BUSYWAIT = i_req & ~((state_q == StDone) && (grant_q == GrantI));
    assign D_BUSYWAIT = d_req & ~((state_q == StDone) && (grant_q == GrantD));

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter with a behavioural main memory of variable latency.
module tb_memory_arbiter;

    localparam int AW = 6;
    localparam int BW = 128;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ, D_READ, D_WRITE;
    logic [AW-1:0] I_ADDRESS, D_ADDRESS;
    logic [BW-1:0] D_WRITEDATA;
    logic [BW-1:0] I_READDATA, D_READDATA;
    logic          I_BUSYWAIT, D_BUSYWAIT;
    logic          MEM_READ, MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [BW-1:0] MEM_WRITEDATA, MEM_READDATA;
    logic          MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    memory_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA),
        .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
        .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Main memory model: busy for 'lat' strobe cycles, then ready.
    logic [BW-1:0] mem [64];
    int            lat = 0;
    int            cnt = 0;
    logic          model_busy = 1'b0;
    logic          mem_manual = 1'b0;
    logic          man_busy   = 1'b0;
    logic [BW-1:0] man_rdata  = '0;

    assign MEM_BUSYWAIT = mem_manual ? man_busy : model_busy;
    assign MEM_READDATA = mem_manual ? man_rdata : mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_manual && MEM_WRITE && !MEM_BUSYWAIT) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        #1;
        if (MEM_READ || MEM_WRITE) begin
            if (cnt < lat) begin
                model_busy = 1'b1;
                cnt++;
            end else begin
                model_busy = 1'b0;
            end
        end else begin
            cnt        = 0;
            model_busy = 1'b0;
        end
    end

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } txn_t;

    txn_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [BW-1:0] exp_i_rd = '0;
    logic [BW-1:0] exp_d_rd = '0;
    logic [AW-1:0] seen_addr = '0;
    logic [BW-1:0] seen_wdata = '0;
    logic          seen_rd = 1'b0;
    logic          seen_wr = 1'b0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_i(input logic [AW-1:0] a);
        txn_t t;
        I_READ    = 1'b1;
        I_ADDRESS = a;
        t = '{is_d: 1'b0, wr: 1'b0, addr: a, data: mem[a]};
        sb.push_back(t);
    endtask

    task automatic push_d(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [BW-1:0] wd);
        txn_t t;
        D_READ      = rd;
        D_WRITE     = wr;
        D_ADDRESS   = a;
        D_WRITEDATA = wd;
        t = '{is_d: 1'b1, wr: wr, addr: a, data: wr ? wd : mem[a]};
        sb.push_back(t);
    endtask

    task automatic complete(input logic is_d);
        txn_t e;
        check_eq("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq("owner", is_d, e.is_d);
        check_eq("mem_addr", seen_addr, e.addr);
        check_eq("mem_rw", {seen_rd, seen_wr}, e.wr ? 2'b01 : 2'b10);
        if (e.wr) begin
            check_eq("mem_wdata", seen_wdata, e.data);
            check_eq("mem_commit", mem[e.addr], e.data);
        end else if (e.is_d) begin
            exp_d_rd = e.data;
        end else begin
            exp_i_rd = e.data;
        end
        check_eq("i_readdata", I_READDATA, exp_i_rd);
        check_eq("d_readdata", D_READDATA, exp_d_rd);
        seen_rd = 1'b0;
        seen_wr = 1'b0;
    endtask

    // Watch the memory port and retire scoreboard entries as busywaits drop.
    task automatic run_until_empty(input int budget, input logic hold_i);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
            if (MEM_READ || MEM_WRITE) begin
                check_eq("mem_excl", MEM_READ & MEM_WRITE, 1'b0);
                seen_addr  = MEM_ADDRESS;
                seen_wdata = MEM_WRITEDATA;
                seen_rd    = seen_rd | MEM_READ;
                seen_wr    = seen_wr | MEM_WRITE;
            end
            if (I_READ && !I_BUSYWAIT) begin
                complete(1'b0);
                if (!hold_i) I_READ = 1'b0;
            end else if ((D_READ || D_WRITE) && !D_BUSYWAIT) begin
                complete(1'b1);
                D_READ  = 1'b0;
                D_WRITE = 1'b0;
            end
        end
        check_eq("drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        logic          got;
        logic [BW-1:0] expv;
        int            kind;
        logic [AW-1:0] a;

        for (int i = 0; i < 64; i++) mem[i] = {4{32'hC0DE_0000 | i}};
        mem[5] = {16{8'hA5}};
        RESET = 1'b1;
        I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        check_eq("rst_mem_read", MEM_READ, 1'b0);
        check_eq("rst_mem_write", MEM_WRITE, 1'b0);
        check_eq("rst_mem_addr", MEM_ADDRESS, '0);
        check_eq("rst_mem_wdata", MEM_WRITEDATA, '0);
        check_eq("rst_i_rd", I_READDATA, '0);
        check_eq("rst_d_rd", D_READDATA, '0);
        check_eq("rst_i_busy", I_BUSYWAIT, 1'b0);
        check_eq("rst_d_busy", D_BUSYWAIT, 1'b0);
        RESET = 1'b0;
        @(negedge CLK);

        // Tie right after reset: D first, then I.
        push_d(1'b1, 1'b0, 6'h0A, '0);
        push_i(6'h07);
        run_until_empty(60, 1'b0);
        // Next tie again favours D, since I was granted last.
        push_d(1'b1, 1'b0, 6'h0B, '0);
        push_i(6'h0C);
        run_until_empty(60, 1'b0);
        // After a lone D grant, a tie goes to I.
        push_d(1'b1, 1'b0, 6'h0D, '0);
        run_until_empty(30, 1'b0);
        push_i(6'h0E);
        push_d(1'b1, 1'b0, 6'h0F, '0);
        run_until_empty(60, 1'b0);

        // I read with three busy cycles; busywait low for one cycle only.
        lat = 3;
        push_i(6'h05);
        run_until_empty(30, 1'b1);
        @(negedge CLK);
        check_eq("i_busy_one_cycle", I_BUSYWAIT, 1'b1);
        I_READ = 1'b0;
        @(negedge CLK);

        // Write-back leaves D_READDATA alone.
        lat = 2;
        push_d(1'b0, 1'b1, 6'h3F, 128'h1234);
        run_until_empty(30, 1'b0);
        // Read and write together is a write.
        push_d(1'b1, 1'b1, 6'h21, 128'hFEED_BEEF_0000_1111);
        run_until_empty(30, 1'b0);

        // Mixed random traffic.
        for (int k = 0; k < 8; k++) begin
            lat  = $urandom_range(0, 3);
            a    = AW'($urandom_range(0, 63));
            kind = $urandom_range(0, 2);
            if (kind == 0) push_i(a);
            else if (kind == 1) push_d(1'b1, 1'b0, a, '0);
            else push_d(1'b0, 1'b1, a, {$urandom, $urandom, $urandom, $urandom});
            run_until_empty(30, 1'b0);
        end

        // Ready during the first strobe cycle must be ignored.
        mem_manual = 1'b1;
        man_busy   = 1'b1;
        D_READ     = 1'b1;
        D_ADDRESS  = 6'h11;
        expv       = mem[6'h11];
        got        = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge CLK);
            if (MEM_READ) got = 1'b1;
        end
        check_eq("issue_strobe", got, 1'b1);
        man_busy  = 1'b0;
        man_rdata = expv;
        @(negedge CLK);
        man_busy = 1'b1;
        check_eq("issue_ignored", D_BUSYWAIT, 1'b1);
        repeat (4) begin
            @(negedge CLK);
            check_eq("wait_hold_rd", MEM_READ, 1'b1);
            check_eq("wait_hold_busy", D_BUSYWAIT, 1'b1);
        end
        man_busy = 1'b0;
        @(negedge CLK);
        check_eq("wait_release", D_BUSYWAIT, 1'b0);
        check_eq("manual_d_rd", D_READDATA, expv);
        D_READ     = 1'b0;
        mem_manual = 1'b0;
        exp_d_rd   = expv;
        @(negedge CLK);

        // Reset during WAIT of an I read aborts it.
        lat       = 6;
        I_READ    = 1'b1;
        I_ADDRESS = 6'h09;
        got       = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge CLK);
            if (MEM_READ) got = 1'b1;
        end
        check_eq("abort_strobe", got, 1'b1);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_eq("abort_mem_read", MEM_READ, 1'b0);
        check_eq("abort_mem_addr", MEM_ADDRESS, '0);
        check_eq("abort_i_rd", I_READDATA, '0);
        check_eq("abort_d_rd", D_READDATA, '0);
        check_eq("abort_i_busy", I_BUSYWAIT, 1'b1);
        RESET  = 1'b0;
        I_READ = 1'b0;
        repeat (10) @(negedge CLK);
        check_eq("abort_no_capture", I_READDATA, '0);
        check_eq("abort_idle_read", MEM_READ, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, block address width.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 128, data block width.
REQ-003 SHALL use one clock, CLK; reset is synchronous and active-high, RESET.
REQ-004 CLK  input  1  system clock; all state updates on posedge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 I_READ  input  1  instruction-cache block read request.
REQ-007 I_ADDRESS  input  ADDR_WIDTH  instruction-cache block address.
REQ-008 I_READDATA  output  BLOCK_WIDTH  registered block returned to instruction cache.
REQ-009 I_BUSYWAIT  output  1  instruction-cache stall.
REQ-010 D_READ  input  1  data-cache block read request.
REQ-011 D_WRITE  input  1  data-cache block write-back request.
REQ-012 D_ADDRESS  input  ADDR_WIDTH  data-cache block address.
REQ-013 D_WRITEDATA  input  BLOCK_WIDTH  data-cache write-back block.
REQ-014 D_READDATA  output  BLOCK_WIDTH  registered block returned to data cache.
REQ-015 D_BUSYWAIT  output  1  data-cache stall.
REQ-016 MEM_READ, MEM_WRITE  output  1 each  registered main-memory strobes.
REQ-017 MEM_ADDRESS  output  ADDR_WIDTH; MEM_WRITEDATA  output  BLOCK_WIDTH; both registered.
REQ-018 MEM_READDATA  input  BLOCK_WIDTH; MEM_BUSYWAIT  input  1; main-memory response.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE plus registers GRANT (I or D) and LAST_GRANT.
REQ-020 IDLE: memory strobes 0; if no request (I_READ, D_READ|D_WRITE) stay IDLE.
REQ-021 IDLE with exactly one request: grant it, latch its address (and D_WRITEDATA for writes) into MEM_* outputs, assert matching strobe, go ISSUE.
REQ-022 IDLE with both requesting: grant the requester not equal to LAST_GRANT (round-robin).
REQ-023 On every grant, LAST_GRANT SHALL take the granted requester.
REQ-024 D_READ and D_WRITE both high SHALL be treated as a write.
REQ-025 ISSUE: lasts exactly one cycle, MEM_BUSYWAIT ignored, strobes held, go WAIT.
REQ-026 WAIT: strobes, address, writedata held; on posedge with MEM_BUSYWAIT=0 capture MEM_READDATA into granted requester's READDATA (reads only), clear strobes, go DONE; else stay WAIT.
REQ-027 Write completion SHALL leave D_READDATA unchanged; non-granted READDATA SHALL never change.
REQ-028 DONE: one cycle, strobes 0, go IDLE unconditionally.
REQ-029 X_BUSYWAIT (combinational) = X requesting AND NOT (state DONE AND GRANT=X).
REQ-030 Minimum latency: request visible before edge E0 -> granted busywait low in cycle after E2 when MEM_BUSYWAIT=0 at E2.
REQ-031 Requester inputs changing while granted SHALL NOT affect the transaction in flight; a request dropped mid-grant still completes.
REQ-032 A request still asserted in DONE SHALL be arbitrated again as new in the following IDLE.
REQ-033 MEM_READ and MEM_WRITE SHALL never be high simultaneously.

Reset
REQ-034 RESET high at posedge SHALL force IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, I_READDATA=0, D_READDATA=0, GRANT=I, LAST_GRANT=I.
REQ-035 RESET mid-transaction SHALL abort it: no READDATA capture, strobes 0 from the next cycle, busywait follows REQ-029.
REQ-036 RESET SHALL take priority over all other events in the same cycle.

Verification
REQ-037 I_READ=1, I_ADDRESS=6'h05, memory busywait 3 cycles then MEM_READDATA=128'hA5.. -> MEM_READ=1, MEM_ADDRESS=5; I_READDATA=128'hA5..; I_BUSYWAIT low one cycle.
REQ-038 I_READ and D_READ rise together after reset -> D granted first (LAST_GRANT=I), I granted next; third tie goes to D.
REQ-039 D_WRITE=1, D_ADDRESS=6'h3F, D_WRITEDATA=128'h1234 -> MEM_WRITE=1, MEM_WRITEDATA=128'h1234, MEM_READ=0; D_READDATA unchanged.
REQ-040 D_READ=D_WRITE=1 -> write performed, MEM_READ stays 0.
REQ-041 RESET pulsed during WAIT of I read -> IDLE next cycle, strobes 0, I_READDATA=0, no later capture.
REQ-042 MEM_BUSYWAIT=0 during ISSUE then high -> arbiter remains in WAIT until MEM_BUSYWAIT falls.
